// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC'97 command sequencer: FSM states,
// the fixed codec init table and the master-volume command encoding.
package ac97_pkg;

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    INIT       = 2'd1,
    IDLE       = 2'd2,
    VOL        = 2'd3
  } state_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } cmd_t;

  localparam int INIT_LEN = 4;
  localparam int IDX_W = $clog2(INIT_LEN);
  localparam logic [6:0] REG_MASTER_VOL = 7'h02;

  function automatic cmd_t init_entry(input logic [IDX_W-1:0] idx);
    cmd_t c;
    case (idx)
      2'd0:    c = '{addr: 7'h02, data: 16'h0000};
      2'd1:    c = '{addr: 7'h18, data: 16'h0808};
      2'd2:    c = '{addr: 7'h1A, data: 16'h0000};
      default: c = '{addr: 7'h1C, data: 16'h0F0F};
    endcase
    return c;
  endfunction

  // Same attenuation on left and right channels, mute bit left clear.
  function automatic logic [15:0] vol_word(input logic [4:0] v);
    return {3'b000, v, 3'b000, v};
  endfunction

endpackage

// File: rtl/ac97_frame_counter.sv
// Counts frame_start pulses; tc flags the pulse that reaches limit.
// Shared between the codec-ready timeout and the per-command hold.
module ac97_frame_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = inc && (count == limit - W'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ac97_cmd_sequencer.sv
// Slot 1/2 command scheduler: waits for codec ready, plays the init table,
// then issues coalesced master-volume writes, one command per hold window.
module ac97_cmd_sequencer
  import ac97_pkg::*;
#(
  parameter int HOLD_FRAMES   = 2,
  parameter int READY_TIMEOUT = 4096
) (
  input  logic        ac97_bit_clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        codec_ready,
  input  logic        vol_req,
  input  logic [4:0]  vol_value,
  output logic        vol_ack,
  output logic        cmd_valid,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        init_done,
  output logic        busy,
  output logic        ready_timeout,
  output state_t      fsm_state
);

  localparam int MAX_LIM = (READY_TIMEOUT > HOLD_FRAMES) ? READY_TIMEOUT : HOLD_FRAMES;
  localparam int CNT_W = $clog2(MAX_LIM + 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic [4:0]       pend_val;
  logic [4:0]       act_val;
  logic             abort;
  logic             cnt_tc;
  logic             cnt_clear;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_limit;
  cmd_t             cur_entry;

  // Link loss only matters once the codec has been initialised.
  assign abort     = frame_start && !codec_ready;
  assign cnt_inc   = frame_start && (state != IDLE);
  assign cnt_limit = (state == WAIT_READY) ? CNT_W'(READY_TIMEOUT) : CNT_W'(HOLD_FRAMES);
  assign cnt_clear = (state_next != state) || cnt_tc;
  assign cur_entry = init_entry(idx);
  assign fsm_state = state;

  ac97_frame_counter #(.W(CNT_W)) u_frame_counter (
    .clk   (ac97_bit_clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      state <= WAIT_READY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_READY: if (frame_start && codec_ready) state_next = INIT;
      INIT:       if (cnt_tc && (idx == IDX_W'(INIT_LEN - 1))) state_next = IDLE;
      IDLE: begin
        if (abort)        state_next = WAIT_READY;
        else if (pending) state_next = VOL;
      end
      VOL: begin
        if (abort)       state_next = WAIT_READY;
        else if (cnt_tc) state_next = IDLE;
      end
      default: state_next = WAIT_READY;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    init_done = 1'b0;
    case (state)
      INIT: begin
        cmd_valid = 1'b1;
        cmd_addr  = cur_entry.addr;
        cmd_data  = cur_entry.data;
      end
      IDLE: init_done = 1'b1;
      VOL: begin
        cmd_valid = 1'b1;
        cmd_addr  = REG_MASTER_VOL;
        cmd_data  = vol_word(act_val);
        init_done = 1'b1;
      end
      default: ;
    endcase
    busy = cmd_valid | pending;
  end

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      idx           <= '0;
      pending       <= 1'b0;
      pend_val      <= '0;
      act_val       <= '0;
      vol_ack       <= 1'b0;
      ready_timeout <= 1'b0;
    end else begin
      vol_ack <= vol_req;
      if (state == IDLE && state_next == VOL) begin
        act_val <= pend_val;
        pending <= 1'b0;
      end
      // An aborted volume write is re-queued; pend_val still holds it or a newer value.
      if (state == VOL && abort) begin
        pending <= 1'b1;
      end
      if (vol_req) begin
        pending  <= 1'b1;
        pend_val <= vol_value;
      end
      if (state == WAIT_READY) begin
        idx <= '0;
      end else if (state == INIT && cnt_tc) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == WAIT_READY && cnt_tc) begin
        ready_timeout <= 1'b1;
      end
    end
  end

endmodule
